// File: rtl/fp_norm_seq.sv
// -----------------------------------------------------------------------------
// fp_norm_seq
// Sequential post-add normaliser for the floating-point adder datapath.
// Takes the raw mantissa sum and carry-out from the mantissa adder, plus the
// pre-aligned exponent and result sign. It renormalises the mantissa so the
// hidden bit is 1. A carry-out costs a single right shift. Cancellation is
// fixed by left shifts, one bit per clock. The block flags zero, overflow and
// underflow and hands the result on over a valid/ready handshake.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready upstream handshake; in_ready is high only while idle
//   in_sign, in_exp, in_mant, in_cout   adder result to be normalised
//   out_valid/out_ready downstream handshake; outputs held while stalled
//   out_sign, out_exp, out_mant         normalised result
//   out_zero, out_overflow, out_underflow  mutually exclusive status flags
//   out_shift_cnt     number of left shifts performed for this result
// -----------------------------------------------------------------------------
module fp_norm_seq #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8,
    localparam int CNT_W = $clog2(MANT_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [MANT_W-1:0] in_mant,
    input  logic              in_cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MANT_W-1:0] out_mant,
    output logic              out_zero,
    output logic              out_overflow,
    output logic              out_underflow,
    output logic [CNT_W-1:0]  out_shift_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};

    state_t              state_r, state_nxt_s;

    // Working copy of the operand while it is being shifted left.
    logic                work_sign_r, work_sign_nxt_s;
    logic [EXP_W-1:0]    work_exp_r, work_exp_nxt_s;
    logic [MANT_W-1:0]   work_mant_r, work_mant_nxt_s;
    logic [CNT_W-1:0]    cnt_r, cnt_nxt_s;

    // Result presented to the output registers when load_out_s is set.
    logic                load_out_s;
    logic                res_sign_s;
    logic [EXP_W-1:0]    res_exp_s;
    logic [MANT_W-1:0]   res_mant_s;
    logic                res_zero_s;
    logic                res_ovf_s;
    logic                res_unf_s;
    logic [CNT_W-1:0]    res_cnt_s;

    // One step of the left-shift loop.
    logic [MANT_W-1:0]   shl_mant_s;
    logic [EXP_W-1:0]    dec_exp_s;
    logic [CNT_W-1:0]    inc_cnt_s;

    logic                in_ready_r;
    logic                out_valid_r;
    logic                out_sign_r;
    logic [EXP_W-1:0]    out_exp_r;
    logic [MANT_W-1:0]   out_mant_r;
    logic                out_zero_r;
    logic                out_overflow_r;
    logic                out_underflow_r;
    logic [CNT_W-1:0]    out_shift_cnt_r;

    assign shl_mant_s = {work_mant_r[MANT_W-2:0], 1'b0};
    assign dec_exp_s  = work_exp_r - EXP_W'(1);
    assign inc_cnt_s  = cnt_r + CNT_W'(1);

    // Next-state, working-register and result selection.
    always_comb begin
        state_nxt_s     = state_r;
        work_sign_nxt_s = work_sign_r;
        work_exp_nxt_s  = work_exp_r;
        work_mant_nxt_s = work_mant_r;
        cnt_nxt_s       = cnt_r;
        load_out_s      = 1'b0;
        res_sign_s      = work_sign_r;
        res_exp_s       = work_exp_r;
        res_mant_s      = work_mant_r;
        res_zero_s      = 1'b0;
        res_ovf_s       = 1'b0;
        res_unf_s       = 1'b0;
        res_cnt_s       = {CNT_W{1'b0}};

        case (state_r)
            IDLE: begin
                if (in_valid) begin
                    work_sign_nxt_s = in_sign;
                    work_exp_nxt_s  = in_exp;
                    work_mant_nxt_s = in_mant;
                    cnt_nxt_s       = {CNT_W{1'b0}};
                    res_sign_s      = in_sign;
                    res_exp_s       = in_exp;
                    res_mant_s      = in_mant;
                    // Rule order matters: the first match wins.
                    if (in_exp == EXP_ONES) begin
                        res_ovf_s   = 1'b1;
                        load_out_s  = 1'b1;
                        state_nxt_s = DONE;
                    end else if (in_cout && (in_exp == EXP_ONES - EXP_W'(1))) begin
                        // Carry would push the exponent into the inf code.
                        res_exp_s   = EXP_ONES;
                        res_mant_s  = {MANT_W{1'b0}};
                        res_ovf_s   = 1'b1;
                        load_out_s  = 1'b1;
                        state_nxt_s = DONE;
                    end else if (in_cout) begin
                        // Carry becomes the new hidden bit; LSB is truncated.
                        res_exp_s   = in_exp + EXP_W'(1);
                        res_mant_s  = {1'b1, in_mant[MANT_W-1:1]};
                        load_out_s  = 1'b1;
                        state_nxt_s = DONE;
                    end else if (in_mant == {MANT_W{1'b0}}) begin
                        res_exp_s   = {EXP_W{1'b0}};
                        res_mant_s  = {MANT_W{1'b0}};
                        res_zero_s  = 1'b1;
                        load_out_s  = 1'b1;
                        state_nxt_s = DONE;
                    end else if (in_mant[MANT_W-1]) begin
                        load_out_s  = 1'b1;
                        state_nxt_s = DONE;
                    end else if (in_exp <= EXP_W'(1)) begin
                        // No exponent headroom to shift into: denormal.
                        res_exp_s   = {EXP_W{1'b0}};
                        res_unf_s   = 1'b1;
                        load_out_s  = 1'b1;
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = SHIFT;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end

            SHIFT: begin
                work_mant_nxt_s = shl_mant_s;
                work_exp_nxt_s  = dec_exp_s;
                cnt_nxt_s       = inc_cnt_s;
                res_sign_s      = work_sign_r;
                res_mant_s      = shl_mant_s;
                res_exp_s       = dec_exp_s;
                res_cnt_s       = inc_cnt_s;
                if (shl_mant_s[MANT_W-1]) begin
                    load_out_s  = 1'b1;
                    state_nxt_s = DONE;
                end else if (dec_exp_s == EXP_W'(1)) begin
                    // Exponent exhausted before the hidden bit appeared.
                    res_exp_s   = {EXP_W{1'b0}};
                    res_unf_s   = 1'b1;
                    load_out_s  = 1'b1;
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = SHIFT;
                end
            end

            DONE: begin
                if (out_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end

            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State and working registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            work_sign_r <= 1'b0;
            work_exp_r  <= {EXP_W{1'b0}};
            work_mant_r <= {MANT_W{1'b0}};
            cnt_r       <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            work_sign_r <= work_sign_nxt_s;
            work_exp_r  <= work_exp_nxt_s;
            work_mant_r <= work_mant_nxt_s;
            cnt_r       <= cnt_nxt_s;
        end
    end

    // Handshake outputs, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_nxt_s == IDLE);
            out_valid_r <= (state_nxt_s == DONE);
        end
    end

    // Result registers; they change only on the transition into DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sign_r      <= 1'b0;
            out_exp_r       <= {EXP_W{1'b0}};
            out_mant_r      <= {MANT_W{1'b0}};
            out_zero_r      <= 1'b0;
            out_overflow_r  <= 1'b0;
            out_underflow_r <= 1'b0;
            out_shift_cnt_r <= {CNT_W{1'b0}};
        end else if (load_out_s) begin
            out_sign_r      <= res_sign_s;
            out_exp_r       <= res_exp_s;
            out_mant_r      <= res_mant_s;
            out_zero_r      <= res_zero_s;
            out_overflow_r  <= res_ovf_s;
            out_underflow_r <= res_unf_s;
            out_shift_cnt_r <= res_cnt_s;
        end else begin
            out_sign_r      <= out_sign_r;
            out_exp_r       <= out_exp_r;
            out_mant_r      <= out_mant_r;
            out_zero_r      <= out_zero_r;
            out_overflow_r  <= out_overflow_r;
            out_underflow_r <= out_underflow_r;
            out_shift_cnt_r <= out_shift_cnt_r;
        end
    end

    assign in_ready      = in_ready_r;
    assign out_valid     = out_valid_r;
    assign out_sign      = out_sign_r;
    assign out_exp       = out_exp_r;
    assign out_mant      = out_mant_r;
    assign out_zero      = out_zero_r;
    assign out_overflow  = out_overflow_r;
    assign out_underflow = out_underflow_r;
    assign out_shift_cnt = out_shift_cnt_r;

endmodule

// File: tb/tb_fp_norm_seq.sv
// -----------------------------------------------------------------------------
// tb_fp_norm_seq
// Self-checking bench for fp_norm_seq with MANT_W=4, EXP_W=4. Expected results
// come from an arithmetic reference model (leading-zero count against the
// available exponent headroom) and from the handshake timing rules.
// -----------------------------------------------------------------------------
module tb_fp_norm_seq;

    localparam int MW = 4;
    localparam int EW = 4;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_sign = 1'b0;
    logic [EW-1:0] in_exp = '0;
    logic [MW-1:0] in_mant = '0;
    logic          in_cout = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_sign;
    logic [EW-1:0] out_exp;
    logic [MW-1:0] out_mant;
    logic          out_zero;
    logic          out_overflow;
    logic          out_underflow;
    logic [CW-1:0] out_shift_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic          sign;
        logic [EW-1:0] exp;
        logic [MW-1:0] mant;
        logic          zero;
        logic          ovf;
        logic          unf;
        logic [CW-1:0] cnt;
    } res_t;

    typedef struct packed {
        logic          s;
        logic [EW-1:0] e;
        logic [MW-1:0] m;
        logic          c;
    } vec_t;

    fp_norm_seq #(.MANT_W(MW), .EXP_W(EW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_cout(in_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_mant(out_mant),
        .out_zero(out_zero), .out_overflow(out_overflow),
        .out_underflow(out_underflow), .out_shift_cnt(out_shift_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: value-level view of the normalisation rules.
    function automatic res_t model(input logic s, input logic [EW-1:0] e,
                                   input logic [MW-1:0] m, input logic c);
        res_t r;
        int mv, ev, lz, avail, tmp;
        r = '0;
        r.sign = s;
        mv = int'(m);
        ev = int'(e);
        if (ev == 15) begin
            r.exp = e; r.mant = m; r.ovf = 1'b1;
        end else if (c && ev == 14) begin
            r.exp = 4'd15; r.mant = 4'd0; r.ovf = 1'b1;
        end else if (c) begin
            tmp = ev + 1;          r.exp = tmp[3:0];
            tmp = (mv / 2) + 8;    r.mant = tmp[3:0];
        end else if (mv == 0) begin
            r.zero = 1'b1;
        end else if (mv >= 8) begin
            r.exp = e; r.mant = m;
        end else if (ev <= 1) begin
            r.mant = m; r.unf = 1'b1;
        end else begin
            lz = 0;
            while ((mv * (2 ** lz)) < 8) lz++;
            avail = ev - 1;
            if (lz <= avail) begin
                tmp = mv * (2 ** lz);  r.mant = tmp[3:0];
                tmp = ev - lz;         r.exp = tmp[3:0];
                r.cnt = CW'(lz);
            end else begin
                tmp = mv * (2 ** avail); r.mant = tmp[3:0];
                r.unf = 1'b1;
                r.cnt = CW'(avail);
            end
        end
        return r;
    endfunction

    function automatic res_t observed();
        return {out_sign, out_exp, out_mant, out_zero, out_overflow,
                out_underflow, out_shift_cnt};
    endfunction

    // Drive one accept and wait (bounded) for out_valid; edges counts clock
    // edges from the accept edge up to the edge that raised out_valid.
    task automatic run_txn(input logic s, input logic [EW-1:0] e,
                           input logic [MW-1:0] m, input logic c, output int edges);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        in_sign = s; in_exp = e; in_mant = m; in_cout = c; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        edges = 1;
        while (!out_valid && edges < 50) begin
            @(posedge clk); #1; edges++;
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++;
        if ({out_valid, in_ready, observed()} !== {1'b0, 1'b1, 15'h0}) begin
            errors++;
            $display("FAIL reset_state: got valid=%b ready=%b res=%h want valid=0 ready=1 res=0",
                     out_valid, in_ready, observed());
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        vec_t vecs[8];
        res_t exp_r;
        int   edges;
        vecs[0] = '{s:1'b0, e:4'd5,  m:4'b1100, c:1'b1};  // carry
        vecs[1] = '{s:1'b1, e:4'd5,  m:4'b0011, c:1'b0};  // cancellation
        vecs[2] = '{s:1'b0, e:4'd2,  m:4'b0001, c:1'b0};  // underflow after shift
        vecs[3] = '{s:1'b1, e:4'd1,  m:4'b0100, c:1'b0};  // immediate underflow
        vecs[4] = '{s:1'b1, e:4'd7,  m:4'b0000, c:1'b0};  // zero
        vecs[5] = '{s:1'b0, e:4'd14, m:4'b1000, c:1'b1};  // carry overflow
        vecs[6] = '{s:1'b1, e:4'd15, m:4'b0101, c:1'b0};  // inf passthrough
        vecs[7] = '{s:1'b0, e:4'd9,  m:4'b1010, c:1'b0};  // already normal
        for (int i = 0; i < 8; i++) begin
            exp_r = model(vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].c);
            run_txn(vecs[i].s, vecs[i].e, vecs[i].m, vecs[i].c, edges);
            checks++;
            if (observed() !== exp_r) begin
                errors++;
                $display("FAIL directed_result[%0d]: got %h want %h", i, observed(), exp_r);
            end
            checks++;
            if (edges !== int'(exp_r.cnt) + 1) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d edges want %0d", i, edges,
                         int'(exp_r.cnt) + 1);
            end
            release_out();
        end
    endtask

    task automatic test_random();
        res_t exp_r;
        int   edges;
        logic s, c;
        logic [EW-1:0] e;
        logic [MW-1:0] m;
        for (int i = 0; i < 200; i++) begin
            s = 1'($urandom); c = 1'($urandom_range(0, 3) == 0);
            e = 4'($urandom); m = 4'($urandom);
            exp_r = model(s, e, m, c);
            run_txn(s, e, m, c, edges);
            checks++;
            if (observed() !== exp_r || edges !== int'(exp_r.cnt) + 1) begin
                errors++;
                $display("FAIL random[%0d] s=%b e=%h m=%h c=%b: got %h lat %0d want %h lat %0d",
                         i, s, e, m, c, observed(), edges, exp_r, int'(exp_r.cnt) + 1);
            end
            checks++;
            if ($countones({out_zero, out_overflow, out_underflow}) > 1) begin
                errors++;
                $display("FAIL flag_exclusive[%0d]: got %b%b%b want at most one set",
                         i, out_zero, out_overflow, out_underflow);
            end
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
            release_out();
        end
    endtask

    task automatic test_back_to_back();
        res_t held, exp_r;
        int   edges;
        run_txn(1'b0, 4'd5, 4'b1100, 1'b1, edges);
        held = observed();
        // New data offered while stalled must be ignored.
        in_sign = 1'b1; in_exp = 4'd3; in_mant = 4'b0110; in_cout = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({out_valid, in_ready, observed()} !== {1'b1, 1'b0, held}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got valid=%b ready=%b res=%h want valid=1 ready=0 res=%h",
                         i, out_valid, in_ready, observed(), held);
            end
        end
        in_valid = 1'b0;
        release_out();
        checks++;
        if ({out_valid, in_ready, observed()} !== {1'b0, 1'b1, held}) begin
            errors++;
            $display("FAIL stall_release: got valid=%b ready=%b res=%h want valid=0 ready=1 res=%h",
                     out_valid, in_ready, observed(), held);
        end
        exp_r = model(1'b1, 4'd6, 4'b0010, 1'b0);
        run_txn(1'b1, 4'd6, 4'b0010, 1'b0, edges);
        checks++;
        if (observed() !== exp_r || edges !== int'(exp_r.cnt) + 1) begin
            errors++;
            $display("FAIL after_stall: got %h lat %0d want %h lat %0d", observed(), edges,
                     exp_r, int'(exp_r.cnt) + 1);
        end
        release_out();
    endtask

    task automatic test_reset_mid_shift();
        int edges;
        int seen;
        // Leave nonzero values in the result registers first.
        run_txn(1'b1, 4'd9, 4'b1010, 1'b0, edges);
        release_out();
        in_sign = 1'b1; in_exp = 4'd9; in_mant = 4'b0001; in_cout = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;                      // accept
        in_valid = 1'b0;
        @(posedge clk); #1;                      // one shift done
        checks++;
        if ({out_valid, in_ready} !== 2'b00) begin
            errors++;
            $display("FAIL shift_busy: got valid=%b ready=%b want valid=0 ready=0",
                     out_valid, in_ready);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, observed()} !== {1'b0, 1'b1, 15'h0}) begin
            errors++;
            $display("FAIL async_reset: got valid=%b ready=%b res=%h want valid=0 ready=1 res=0",
                     out_valid, in_ready, observed());
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL no_result_after_reset: got %0d valid cycles ready=%b want 0 and ready=1",
                     seen, in_ready);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid_shift();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
